// File: rtl/arb_pkg.sv
// Shared constants for the 8-way round-robin arbiter.
package arb_pkg;
    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
endpackage

// File: rtl/idx_to_onehot.sv
// Combinational index-to-one-hot decode feeding the registered grant.
module idx_to_onehot #(
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0]      idx_i,
    output logic [2**IDX_W-1:0]   oh_o
);
    always_comb begin
        oh_o        = '0;
        oh_o[idx_i] = 1'b1;
    end
endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with hold timeout and a dead
// cycle between grants so select lines break before they make.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);
    logic [1:0]        state_q;
    logic [IDX_W-1:0]  ptr_q, idx_q, win;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0]  gnt_q, win_oh;
    logic              vld_q, tmo_q;
    logic              tmo_hit, rel_other;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        logic [IDX_W-1:0]   off;
        dbl = {r, r} >> p;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int j = N_REQ - 1; j >= 0; j--)
            if (rot[j]) off = IDX_W'(j);
        return p + off;
    endfunction

    assign win = rr_pick(req, ptr_q);

    idx_to_onehot #(.IDX_W(IDX_W)) u_oh (
        .idx_i (win),
        .oh_o  (win_oh)
    );

    assign tmo_hit   = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign rel_other = done || !req[idx_q];
    assign hold_d    = (&hold_q) ? hold_q : hold_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tmo_q <= 1'b0;
                    if (|req) begin
                        idx_q   <= win;
                        gnt_q   <= win_oh;
                        vld_q   <= 1'b1;
                        hold_q  <= '0;
                        ptr_q   <= win + 1'b1;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (rel_other || tmo_hit) begin
                        gnt_q   <= '0;
                        vld_q   <= 1'b0;
                        tmo_q   <= tmo_hit && !rel_other;
                        state_q <= ST_RELEASE;
                    end else begin
                        hold_q  <= hold_d;
                    end
                end
                ST_RELEASE: begin
                    tmo_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    vld_q   <= 1'b0;
                    tmo_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = vld_q;
    assign timeout   = tmo_q;
endmodule
